imem_refill: RTL and testbench

Line-fill engine between the L1 instruction cache and the word-wide instruction memory port. It accepts a cache-miss or MMIO fetch request from the L1 I-cache (`l1_mmu_req_read` / `l1_mmu_req_addr`) and handles it as follows:
- **Cached address:** fetches the eight 32-bit words of the aligned 32-byte line one at a time and returns them as one 256-bit beat with a single-cycle `mmu_l1_done`.
- **MMIO address:** performs one uncached word read and returns it in bits [31:0].

---
 rtl/imem_pkg.sv | 24 ++
 rtl/imem_refill_if.sv | 41 ++++
 rtl/imem_line_asm.sv | 30 +++
 rtl/imem_refill.sv | 114 +++++++++++
 tb/tb_imem_refill.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory refill path and the L1 MMIO decode.
package imem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    COOL
  } state_t;

  localparam int unsigned LINE_WORDS = 8;
  localparam int unsigned LINE_BYTES = 32;

  localparam logic [31:0] MMIO_BASE = 32'hFFFF_F000;
  localparam logic [31:0] MMIO_MASK = 32'hFFFF_F000;

  function automatic logic is_mmio(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/imem_refill_if.sv
// L1 request/return and word-memory handshake bundle for the refill engine.
interface imem_refill_if;
  import imem_pkg::*;

  logic                      l1_mmu_req_read;
  logic [31:0]               l1_mmu_req_addr;
  logic                      mmu_l1_done;
  logic [LINE_BYTES*8-1:0]   mmu_l1_read_data;

  logic                      mem_req;
  logic [31:0]               mem_addr;
  logic                      mem_gnt;
  logic                      mem_rvalid;
  logic [31:0]               mem_rdata;

  // master: the refill engine; slave: the L1 cache and memory side
  modport master (
    input  l1_mmu_req_read,
    input  l1_mmu_req_addr,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata,
    output mmu_l1_done,
    output mmu_l1_read_data,
    output mem_req,
    output mem_addr
  );

  modport slave (
    output l1_mmu_req_read,
    output l1_mmu_req_addr,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata,
    input  mmu_l1_done,
    input  mmu_l1_read_data,
    input  mem_req,
    input  mem_addr
  );

endinterface

// File: rtl/imem_line_asm.sv
// Line buffer that assembles returned words into a full cache line;
// MMIO writes land in word 0 with every upper word forced to zero.
module imem_line_asm #(
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       we,
  input  logic                       mmio,
  input  logic [2:0]                 sel,
  input  logic [31:0]                wdata,
  output logic [32*LINE_WORDS-1:0]   line
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line <= '0;
    end else if (clr) begin
      line <= '0;
    end else if (we) begin
      if (mmio) begin
        line <= {{(32*(LINE_WORDS-1)){1'b0}}, wdata};
      end else begin
        line[32*sel +: 32] <= wdata;
      end
    end
  end

endmodule

// File: rtl/imem_refill.sv
// Line-fill engine: turns one L1 miss/MMIO request into a sequence of
// single-outstanding word reads and returns the assembled line with a done pulse.
module imem_refill #(
  parameter int unsigned LINE_WORDS = imem_pkg::LINE_WORDS,
  parameter logic [31:0] MMIO_BASE  = imem_pkg::MMIO_BASE,
  parameter logic [31:0] MMIO_MASK  = imem_pkg::MMIO_MASK
) (
  input logic           sys_clk,
  input logic           rst,
  imem_refill_if.master bus
);
  import imem_pkg::*;

  state_t                     state;
  logic [2:0]                 k;
  logic [2:0]                 last;
  logic [2:0]                 k_next;
  logic [31:0]                base;
  logic [31:0]                req_base;
  logic                       mmio;
  logic                       req_mmio;
  logic                       done;
  logic                       mem_req;
  logic [31:0]                mem_addr;
  logic                       buf_clr;
  logic                       buf_we;
  logic [32*LINE_WORDS-1:0]   line;

  always_comb begin
    req_mmio = is_mmio(bus.l1_mmu_req_addr, MMIO_BASE, MMIO_MASK);
    req_base = req_mmio ? {bus.l1_mmu_req_addr[31:2], 2'b00}
                        : {bus.l1_mmu_req_addr[31:5], 5'b0};
    k_next   = k + 3'd1;
    buf_clr  = (state == IDLE) && bus.l1_mmu_req_read;
    buf_we   = (state == WAIT) && bus.mem_rvalid;
  end

  // mem_req/mem_addr are set on the edge entering ISSUE so they are
  // registered and stable for the whole time the request is pending.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      last     <= '0;
      base     <= '0;
      mmio     <= 1'b0;
      done     <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.l1_mmu_req_read) begin
            base     <= req_base;
            mmio     <= req_mmio;
            last     <= req_mmio ? 3'd0 : 3'(LINE_WORDS - 1);
            k        <= '0;
            mem_req  <= 1'b1;
            mem_addr <= req_base;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            if (k == last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              k        <= k_next;
              mem_req  <= 1'b1;
              mem_addr <= base + {27'b0, k_next, 2'b00};
              state    <= ISSUE;
            end
          end
        end
        DONE: begin
          state <= COOL;
        end
        COOL: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  imem_line_asm #(
    .LINE_WORDS(LINE_WORDS)
  ) u_line (
    .clk  (sys_clk),
    .rst  (rst),
    .clr  (buf_clr),
    .we   (buf_we),
    .mmio (mmio),
    .sel  (k),
    .wdata(bus.mem_rdata),
    .line (line)
  );

  assign bus.mmu_l1_done      = done;
  assign bus.mmu_l1_read_data = line;
  assign bus.mem_req          = mem_req;
  assign bus.mem_addr         = mem_addr;

endmodule

// File: tb/tb_imem_refill.sv
// Directed bench for imem_refill: table of fill scenarios against a
// delay-programmable word memory, plus a hand-written reset-mid-fill sequence.
module tb_imem_refill;

  logic sys_clk;
  logic rst;
  int   checks;
  int   errors;

  imem_refill_if bus ();

  imem_refill dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .bus    (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] addr2;
    logic [31:0] seed;
    logic [31:0] base;
    int unsigned chg_cyc;
    int unsigned gnt_word;
    int unsigned gnt_dly;
    int unsigned rv_word;
    int unsigned rv_dly;
    int unsigned linger;
    int unsigned words;
    int unsigned done_cyc;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drives one request from cycle 0 (current cycle) and plays memory; the
  // memory stalls the grant / rvalid of one chosen word by a set number of cycles.
  task automatic run_fill(input vec_t v);
    int unsigned  done_cyc;
    int unsigned  done_cnt;
    int unsigned  w;
    int unsigned  gwait;
    int unsigned  rwait;
    int unsigned  phase;
    int unsigned  bad_req;
    bit           seen;
    logic [255:0] exp_line;
    logic [255:0] got_line;

    exp_line = '0;
    for (int i = 0; i < int'(v.words); i++) exp_line[32*i +: 32] = v.seed + 32'(i);
    done_cyc = 0; done_cnt = 0; w = 0; gwait = 0; rwait = 0; phase = 0;
    bad_req = 0; seen = 1'b0; got_line = '0;

    bus.l1_mmu_req_addr = v.addr;
    bus.l1_mmu_req_read = 1'b1;

    for (int unsigned cyc = 1; cyc <= 80; cyc++) begin
      @(posedge sys_clk); #1;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      if (v.chg_cyc != 0 && cyc == v.chg_cyc) bus.l1_mmu_req_addr = v.addr2;
      if (bus.mmu_l1_done) begin
        done_cnt++;
        if (!seen) begin
          seen     = 1'b1;
          done_cyc = cyc;
          got_line = bus.mmu_l1_read_data;
        end
      end
      if (seen) begin
        if (bus.mem_req) bad_req++;
        if (cyc > done_cyc + v.linger) bus.l1_mmu_req_read = 1'b0;
        if (cyc == done_cyc + 4) break;
      end else if (phase == 0 && bus.mem_req) begin
        check("mem_addr", bus.mem_addr, v.base + 32'(4 * w));
        if (w == v.gnt_word && gwait < v.gnt_dly) begin
          gwait++;
        end else begin
          bus.mem_gnt = 1'b1;
          phase = 1;
          gwait = 0;
        end
      end else if (phase == 1) begin
        if (w == v.rv_word && rwait < v.rv_dly) begin
          rwait++;
        end else begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = v.seed + 32'(w);
          w++;
          phase = 0;
          rwait = 0;
        end
      end
    end
    bus.l1_mmu_req_read = 1'b0;

    check("done_seen", 256'(seen), 256'd1);
    check("done_cycle", 256'(done_cyc), 256'(v.done_cyc));
    check("done_pulses", 256'(done_cnt), 256'd1);
    check("words_read", 256'(w), 256'(v.words));
    check("no_req_after_done", 256'(bad_req), 256'd0);
    check("line_data", got_line, exp_line);
    check("line_hold", bus.mmu_l1_read_data, exp_line);
  endtask

  initial begin
    int unsigned stray_done;
    int unsigned stray_req;
    vec_t        v40;

    checks = 0;
    errors = 0;

    //             addr          addr2         seed          base        chg gw gd rw rd lg wd done
    vecs[0] = '{32'h0000_1234, 32'h0,        32'h0000_00A0, 32'h0000_1220, 0, 8, 0, 8, 0, 0, 8, 17};
    vecs[1] = '{32'hFFFF_F004, 32'h0,        32'hDEAD_BEEF, 32'hFFFF_F004, 0, 8, 0, 8, 0, 0, 1, 3};
    vecs[2] = '{32'h0000_2000, 32'h0,        32'h0000_1000, 32'h0000_2000, 0, 3, 2, 5, 3, 0, 8, 22};
    vecs[3] = '{32'h0000_3000, 32'h0,        32'h0000_0050, 32'h0000_3000, 0, 8, 0, 8, 0, 1, 8, 17};
    vecs[4] = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0077, 32'h0000_0100, 5, 8, 0, 8, 0, 0, 8, 17};
    vecs[5] = '{32'hFFFF_FFFE, 32'h0,        32'h1234_5678, 32'hFFFF_FFFC, 0, 0, 1, 0, 2, 0, 1, 6};
    vecs[6] = '{32'hFFFF_EFFF, 32'h0,        32'h0BAD_F00D, 32'hFFFF_EFE0, 0, 8, 0, 8, 0, 0, 8, 17};
    v40     = '{32'h0000_0040, 32'h0,        32'h0000_00C0, 32'h0000_0040, 0, 8, 0, 8, 0, 0, 8, 17};

    rst                 = 1'b1;
    bus.l1_mmu_req_read = 1'b0;
    bus.l1_mmu_req_addr = '0;
    bus.mem_gnt         = 1'b0;
    bus.mem_rvalid      = 1'b0;
    bus.mem_rdata       = '0;

    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_done", 256'(bus.mmu_l1_done), 256'd0);
    check("rst_mem_req", 256'(bus.mem_req), 256'd0);
    check("rst_mem_addr", 256'(bus.mem_addr), 256'd0);
    check("rst_data", bus.mmu_l1_read_data, 256'd0);
    rst = 1'b0;
    @(posedge sys_clk); #1;

    for (int i = 0; i < 7; i++) run_fill(vecs[i]);

    // Reset during word 4's WAIT (cycle 10), then a stray rvalid.
    bus.l1_mmu_req_addr = 32'h0000_5000;
    bus.l1_mmu_req_read = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge sys_clk); #1;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (c < 10) begin
        if (bus.mem_req) begin
          bus.mem_gnt = 1'b1;
        end else begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = 32'h900 + 32'(c);
        end
      end
    end
    check("pre_rst_in_wait", 256'(bus.mem_req), 256'd0);
    rst = 1'b1;
    bus.l1_mmu_req_read = 1'b0;
    #1;
    check("midrst_done", 256'(bus.mmu_l1_done), 256'd0);
    check("midrst_mem_req", 256'(bus.mem_req), 256'd0);
    check("midrst_mem_addr", 256'(bus.mem_addr), 256'd0);
    check("midrst_data", bus.mmu_l1_read_data, 256'd0);
    @(posedge sys_clk); #1;
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0000_0BAD;
    stray_done = 0;
    stray_req  = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge sys_clk); #1;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      if (bus.mmu_l1_done) stray_done++;
      if (bus.mem_req) stray_req++;
    end
    check("stray_done", 256'(stray_done), 256'd0);
    check("stray_req", 256'(stray_req), 256'd0);
    check("stray_data", bus.mmu_l1_read_data, 256'd0);

    run_fill(v40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
